// File: rtl/booth_pkg.sv
// booth_pkg: shared state/digit types and iteration-count helper for the radix-4 Booth multiplier
package booth_pkg;
   typedef enum logic [2:0] {IDLE, LOAD_Q, CALC, OUT_HI, OUT_LO} booth_state_t;
   typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} booth_digit_t;
   // unsigned operands are zero-extended by two bits, which costs one extra digit
   function automatic int iter_count(input int width, input logic signed_mode);
      return signed_mode ? width / 2 : width / 2 + 1;
   endfunction
endpackage

// File: rtl/booth_r4_recode.sv
// booth_r4_recode: maps a 3-bit Booth window to a digit and the matching partial product
module booth_r4_recode import booth_pkg::*; #(
   parameter int WIDTH = 8
) (
   input  logic [2:0]       win,
   input  logic [WIDTH-1:0] m,
   input  logic             mode,
   output booth_digit_t     digit,
   output logic [WIDTH+1:0] pp
);
   logic [WIDTH+1:0] mext;
   // radix-4 recode table: {q[i+1], q[i], q[i-1]}
   always_comb begin
      case (win)
         3'b001, 3'b010: digit = POS1;
         3'b011:         digit = POS2;
         3'b100:         digit = NEG2;
         3'b101, 3'b110: digit = NEG1;
         default:        digit = ZERO;
      endcase
   end
   // extend the multiplicand to accumulator width, then scale and negate per digit
   always_comb begin
      mext = mode ? {{2{m[WIDTH-1]}}, m} : {2'b00, m};
      pp = digit == POS1 ? mext :
           digit == POS2 ? mext << 1 :
           digit == NEG1 ? -mext :
           digit == NEG2 ? -(mext << 1) : '0;
   end
endmodule

// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential radix-4 Booth multiplier with shared load/unload buses
module booth_mult_seq import booth_pkg::*; #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] inbus,
   output logic [WIDTH-1:0] outbus,
   output logic             busy,
   output logic             done
);
   localparam int CW = $clog2(WIDTH / 2 + 2);
   if (WIDTH % 2 != 0 || WIDTH < 4) begin : g_bad_width
      $error("booth_mult_seq: WIDTH must be even and >= 4");
   end
   booth_state_t state, next;
   booth_digit_t digit;
   logic [WIDTH-1:0] m;
   logic [WIDTH+1:0] acc, q, pp, addend;
   logic [WIDTH+2:0] sum;
   logic [2*WIDTH-1:0] p;
   logic [CW-1:0] cnt;
   logic mode, g, last;
   booth_r4_recode #(.WIDTH(WIDTH)) u_recode (
      .win   ({q[1:0], g}),
      .m     (m),
      .mode  (mode),
      .digit (digit),
      .pp    (pp)
   );
   // add with one guard bit so the sum cannot wrap before the arithmetic shift
   always_comb begin
      addend = digit == ZERO ? '0 : pp;
      sum = {acc[WIDTH+1], acc} + {addend[WIDTH+1], addend};
      last = int'(cnt) == iter_count(WIDTH, mode) - 1;
      p = mode ? {acc[WIDTH-1:0], q[WIDTH+1:2]} : {acc[WIDTH-3:0], q};
   end
   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else state <= next;
   end
   // next state and bus outputs
   always_comb begin
      next = state;
      case (state)
         IDLE:    next = enable ? LOAD_Q : IDLE;
         LOAD_Q:  next = CALC;
         CALC:    next = last ? OUT_HI : CALC;
         OUT_HI:  next = OUT_LO;
         default: next = IDLE;
      endcase
      busy = state != IDLE;
      done = state == OUT_HI || state == OUT_LO;
      outbus = state == OUT_HI ? p[2*WIDTH-1:WIDTH] : state == OUT_LO ? p[WIDTH-1:0] : '0;
   end
   // operand latches and the {acc,q,g} shift register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m <= '0;
         mode <= 1'b0;
         acc <= '0;
         q <= '0;
         g <= 1'b0;
         cnt <= '0;
      end else begin
         case (state)
            IDLE: if (enable) begin
               m <= inbus;
               mode <= signed_mode;
            end
            LOAD_Q: begin
               q <= mode ? {{2{inbus[WIDTH-1]}}, inbus} : {2'b00, inbus};
               acc <= '0;
               g <= 1'b0;
               cnt <= '0;
            end
            CALC: begin
               acc <= {sum[WIDTH+2], sum[WIDTH+2:2]};
               q <= {sum[1:0], q[WIDTH+1:2]};
               g <= q[1];
               cnt <= cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_booth_mult_seq.sv
// tb_booth_mult_seq: directed checks of the Booth multiplier at WIDTH 8 and 16
module tb_booth_mult_seq;
   logic clk = 1'b0, rst = 1'b1;
   logic en8 = 1'b0, sm8 = 1'b0, busy8, done8;
   logic [7:0] in8 = '0, out8;
   logic en16 = 1'b0, sm16 = 1'b0, busy16, done16;
   logic [15:0] in16 = '0, out16;
   int n_pass = 0, n_chk = 0;

   always #5 clk = ~clk;

   booth_mult_seq #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .enable(en8), .signed_mode(sm8),
      .inbus(in8), .outbus(out8), .busy(busy8), .done(done8)
   );
   booth_mult_seq #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .enable(en16), .signed_mode(sm16),
      .inbus(in16), .outbus(out16), .busy(busy16), .done(done16)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_op8(input logic [7:0] mv, input logic [7:0] qv, input logic sm,
                         output logic [7:0] hi, output logic [7:0] lo, output int c_hi, output bit ok);
      int c;
      en8 = 1'b1; in8 = mv; sm8 = sm;
      tick(); c = 1;
      en8 = 1'b0; in8 = qv; sm8 = 1'b0;
      while (!done8 && c < 40) begin tick(); c++; end
      c_hi = c; hi = out8;
      tick(); lo = out8; ok = done8;
      tick(); ok = ok && !done8 && !busy8;
   endtask

   task automatic do_op16(input logic [15:0] mv, input logic [15:0] qv, input logic sm,
                          output logic [15:0] hi, output logic [15:0] lo, output int c_hi, output bit ok);
      int c;
      en16 = 1'b1; in16 = mv; sm16 = sm;
      tick(); c = 1;
      en16 = 1'b0; in16 = qv; sm16 = 1'b0;
      while (!done16 && c < 40) begin tick(); c++; end
      c_hi = c; hi = out16;
      tick(); lo = out16; ok = done16;
      tick(); ok = ok && !done16 && !busy16;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      n_chk++;
      if ({busy8, done8, out8} !== 10'h000) $display("FAIL reset8 got busy=%b done=%b out=%h want 0 0 00", busy8, done8, out8);
      else n_pass++;
      n_chk++;
      if ({busy16, done16, out16} !== 18'h0) $display("FAIL reset16 got busy=%b done=%b out=%h want 0 0 0000", busy16, done16, out16);
      else n_pass++;
      rst = 1'b0;
      tick();
      n_chk++;
      if ({busy8, done8, out8} !== 10'h000) $display("FAIL idle8 got busy=%b done=%b out=%h want 0 0 00", busy8, done8, out8);
      else n_pass++;
   endtask

   task automatic test_products8();
      logic [7:0] mv [6] = '{8'hFD, 8'hFF, 8'h80, 8'h80, 8'h02, 8'hFD};
      logic [7:0] qv [6] = '{8'h05, 8'hFF, 8'h80, 8'h7F, 8'h80, 8'h05};
      logic       sv [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      logic [15:0] pv [6] = '{16'hFFF1, 16'hFE01, 16'h4000, 16'hC080, 16'h0100, 16'h04F1};
      int          cv [6] = '{6, 7, 6, 6, 7, 7};
      logic [7:0] hi, lo;
      int c;
      bit ok;
      for (int i = 0; i < 6; i++) begin
         do_op8(mv[i], qv[i], sv[i], hi, lo, c, ok);
         n_chk++;
         if ({hi, lo} !== pv[i]) $display("FAIL prod8[%0d] got %h%h want %h", i, hi, lo, pv[i]);
         else n_pass++;
         n_chk++;
         if (c !== cv[i]) $display("FAIL latency8[%0d] got cycle %0d want %0d", i, c, cv[i]);
         else n_pass++;
         n_chk++;
         if (!ok) $display("FAIL donepair8[%0d] got ok=%b want 1", i, ok);
         else n_pass++;
      end
   endtask

   task automatic test_width16();
      logic [15:0] hi, lo;
      int c;
      bit ok;
      do_op16(16'h7FFF, 16'h8000, 1'b1, hi, lo, c, ok);
      n_chk++;
      if ({hi, lo, c, ok} !== {32'hC0008000, 32'd10, 1'b1}) $display("FAIL signed16 got %h%h cycle %0d ok=%b want c0008000 cycle 10 ok=1", hi, lo, c, ok);
      else n_pass++;
      do_op16(16'hFFFF, 16'hFFFF, 1'b0, hi, lo, c, ok);
      n_chk++;
      if ({hi, lo, c, ok} !== {32'hFFFE0001, 32'd11, 1'b1}) $display("FAIL unsigned16 got %h%h cycle %0d ok=%b want fffe0001 cycle 11 ok=1", hi, lo, c, ok);
      else n_pass++;
   endtask

   task automatic test_abort();
      logic [7:0] hi, lo;
      int c, nd;
      bit ok;
      en8 = 1'b1; in8 = 8'h7F; sm8 = 1'b1;
      tick();
      en8 = 1'b0;
      tick(); tick();
      rst = 1'b1;
      #1;
      n_chk++;
      if ({busy8, done8, out8} !== 10'h000) $display("FAIL abort got busy=%b done=%b out=%h want 0 0 00", busy8, done8, out8);
      else n_pass++;
      tick();
      rst = 1'b0;
      nd = 0;
      for (int i = 0; i < 12; i++) begin tick(); nd += int'(done8); end
      n_chk++;
      if (nd !== 0) $display("FAIL abort_nodone got %0d done cycles want 0", nd);
      else n_pass++;
      do_op8(8'h03, 8'h04, 1'b1, hi, lo, c, ok);
      n_chk++;
      if ({hi, lo, c, ok} !== {16'h000C, 32'd6, 1'b1}) $display("FAIL after_abort got %h%h cycle %0d ok=%b want 000c cycle 6 ok=1", hi, lo, c, ok);
      else n_pass++;
   endtask

   task automatic test_ignore_enable();
      int nd;
      logic [15:0] got;
      en8 = 1'b1; in8 = 8'hFD; sm8 = 1'b1;
      nd = 0; got = '0;
      for (int c = 1; c <= 20; c++) begin
         tick();
         en8 = c == 3; in8 = c == 3 ? 8'h11 : 8'h05; sm8 = 1'b0;
         if (done8 && c == 6) got[15:8] = out8;
         if (done8 && c == 7) got[7:0] = out8;
         nd += int'(done8);
      end
      en8 = 1'b0;
      n_chk++;
      if (got !== 16'hFFF1) $display("FAIL ignore_en_result got %h want fff1", got);
      else n_pass++;
      n_chk++;
      if (nd !== 2) $display("FAIL ignore_en_pairs got %0d done cycles want 2", nd);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int c;
      logic eb, ed;
      logic [7:0] eo;
      en8 = 1'b1; in8 = 8'h03; sm8 = 1'b1;
      for (c = 1; c <= 16; c++) begin
         tick();
         eb = c % 8 != 0;
         ed = c % 8 == 6 || c % 8 == 7;
         eo = c % 8 == 7 ? 8'h09 : 8'h00;
         n_chk++;
         if ({busy8, done8, out8} !== {eb, ed, eo}) $display("FAIL b2b cycle %0d got busy=%b done=%b out=%h want %b %b %h", c, busy8, done8, out8, eb, ed, eo);
         else n_pass++;
      end
      en8 = 1'b0;
      for (c = 0; c < 40 && busy8 !== 1'b0; c++) tick();
      tick();
      n_chk++;
      if (busy8 !== 1'b0) $display("FAIL b2b_drain got busy=%b want 0", busy8);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_products8();
      test_width16();
      test_abort();
      test_ignore_enable();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
